uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/rr_arb.sv | 33 +++
 rtl/uart_tx_sched.sv | 113 +++++++++++
 tb/tb_uart_tx_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state type and small helpers for the word scheduler.
package uart_pkg;

  localparam int FREQ   = 12000000;
  localparam int BAUD   = 9600;
  localparam int LIM    = FREQ / BAUD;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter bundle of the UART word scheduler.
interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BYTES = 4
);

  logic [NREQ-1:0]              req;
  logic [NREQ*BYTE_W*BYTES-1:0] req_data;
  logic [NREQ-1:0]              gnt;
  logic                         flush;
  logic [BYTE_W-1:0]            tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic                         busy;
  logic [idx_w(NREQ)-1:0]       cur_src;

  modport slave (
    input  req, req_data, flush, tx_ready,
    output gnt, tx_data, tx_valid, busy, cur_src
  );

  modport master (
    output req, req_data, flush, tx_ready,
    input  gnt, tx_data, tx_valid, busy, cur_src
  );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_arb
  import uart_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // Scan from the farthest offset down so the one nearest ptr is written last.
  always_comb begin
    int sel;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sel   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = (int'(ptr) + k) % NREQ;
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
        idx      = IDXW'(sel);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin word scheduler feeding a byte-wide UART transmitter, MSByte first,
// with an idle gap after each word and a synchronous flush of the word in flight.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BYTES = 4,
  parameter int GAP   = LIM
) (
  input logic            clk,
  input logic            nrst,
  uart_tx_sched_if.slave bus
);

  localparam int W    = BYTE_W * BYTES;
  localparam int IDXW = idx_w(NREQ);
  localparam int BCW  = $clog2(BYTES + 1);
  localparam int GCW  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t          state_reg, state_next;
  logic [W-1:0]    shift_reg, shift_next;
  logic [BCW-1:0]  byte_cnt_reg, byte_cnt_next;
  logic [GCW-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [IDXW-1:0] src_reg, src_next;
  logic [NREQ-1:0] grant;

  logic [NREQ-1:0] arb_gnt;
  logic [IDXW-1:0] arb_idx;
  logic            arb_valid;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      ptr_reg      <= '0;
      src_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      byte_cnt_reg <= byte_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      ptr_reg      <= ptr_next;
      src_reg      <= src_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    byte_cnt_next = byte_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    ptr_next      = ptr_reg;
    src_next      = src_reg;
    grant         = '0;
    case (state_reg)
      ST_IDLE: begin
        // The grant is combinational, so keep it quiet while reset is held.
        if (arb_valid && nrst) begin
          grant         = arb_gnt;
          shift_next    = bus.req_data[int'(arb_idx)*W +: W];
          src_next      = arb_idx;
          ptr_next      = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + IDXW'(1);
          byte_cnt_next = '0;
          state_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          shift_next = shift_reg << BYTE_W;
          if (int'(byte_cnt_reg) == BYTES - 1) begin
            byte_cnt_next = '0;
            gap_cnt_next  = '0;
            state_next    = (GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            byte_cnt_next = byte_cnt_reg + BCW'(1);
          end
        end
        if (bus.flush) begin
          state_next    = ST_IDLE;
          byte_cnt_next = '0;
          gap_cnt_next  = '0;
        end
      end
      ST_GAP: begin
        if (int'(gap_cnt_reg) >= GAP - 1 || bus.flush) begin
          gap_cnt_next = '0;
          state_next   = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GCW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.gnt      = grant;
  assign bus.tx_valid = (state_reg == ST_SEND);
  assign bus.tx_data  = shift_reg[W-1 -: BYTE_W];
  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.cur_src  = src_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a word table for arbitration/byte order plus
// hand-written stall, flush and reset sequences.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int BYTES = 4;
  localparam int GAP   = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NREQ(NREQ), .BYTES(BYTES)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .BYTES(BYTES), .GAP(GAP)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   exp_gnt;
    int           exp_src;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [3:0] exp);
    int t = 0;
    while (bus.gnt == '0 && t < 20) begin
      nclk();
      t++;
    end
    check("gnt", bus.gnt, exp);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 50) begin
      nclk();
      t++;
    end
    check("idle_timeout", bus.busy, 0);
  endtask

  task automatic send_bytes(input logic [31:0] word, input int src);
    for (int b = 0; b < BYTES; b++) begin
      check("tx_valid", bus.tx_valid, 1);
      check("tx_data", bus.tx_data, word[31-8*b -: 8]);
      check("cur_src", bus.cur_src, src);
      nclk();
    end
  endtask

  // Full word with tx_ready high: grant, 4 contiguous bytes, GAP busy cycles, idle.
  task automatic run_word(input logic [3:0] exp_gnt, input int src, input logic [31:0] word);
    wait_gnt(exp_gnt);
    @(posedge clk);
    #1;
    bus.req   = '0;
    bus.flush = 1'b0;
    nclk();
    send_bytes(word, src);
    for (int g = 0; g < GAP; g++) begin
      check("gap_busy", bus.busy, 1);
      check("gap_valid", bus.tx_valid, 0);
      nclk();
    end
    check("gap_end_idle", bus.busy, 0);
    $display("word src=%0d data=%h done", src, word);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  prev;
    logic        stalled;
    int          k;
    int          c;

    vecs[0] = '{4'b0001, {96'h0, 32'h536E6170}, 4'b0001, 0};
    vecs[1] = '{4'b1111, 128'h44444444_33333333_22222222_11111111, 4'b0010, 1};
    vecs[2] = '{4'b1111, 128'h44444444_33333333_22222222_11111111, 4'b0100, 2};
    vecs[3] = '{4'b1111, 128'h44444444_33333333_22222222_11111111, 4'b1000, 3};
    vecs[4] = '{4'b1111, 128'h44444444_33333333_22222222_11111111, 4'b0001, 0};
    vecs[5] = '{4'b1001, 128'h44444444_33333333_22222222_11111111, 4'b1000, 3};
    vecs[6] = '{4'b0110, 128'h44444444_33333333_22222222_11111111, 4'b0010, 1};
    vecs[7] = '{4'b0011, 128'h44444444_33333333_22222222_11111111, 4'b0001, 0};

    bus.req      = 4'b1111;
    bus.req_data = '0;
    bus.flush    = 1'b0;
    bus.tx_ready = 1'b1;
    nrst         = 1'b0;
    nclk();
    nclk();
    check("rst_gnt", bus.gnt, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cur_src", bus.cur_src, 0);
    bus.req = '0;
    nrst    = 1'b1;
    nclk();

    for (int i = 0; i < 8; i++) begin
      bus.req      = vecs[i].req;
      bus.req_data = vecs[i].data;
      #1;
      run_word(vecs[i].exp_gnt, vecs[i].exp_src, vecs[i].data[vecs[i].exp_src*32 +: 32]);
    end

    // Stall: tx_ready alternates 1,0,... while data must hold during stalls.
    bus.req      = 4'b0001;
    bus.req_data = {96'h0, 32'h536E6170};
    w            = 32'h536E6170;
    #1;
    wait_gnt(4'b0001);
    @(posedge clk);
    #1;
    bus.req = '0;
    k = 0; c = 0; stalled = 1'b0; prev = '0;
    while (k < BYTES && c < 20) begin
      @(negedge clk);
      bus.tx_ready = (c % 2 == 0);
      #1;
      if (stalled) begin
        check("stall_valid", bus.tx_valid, 1);
        check("stall_data", bus.tx_data, prev);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        check("stall_byte", bus.tx_data, w[31-8*k -: 8]);
        k++;
        stalled = 1'b0;
      end else if (bus.tx_valid) begin
        stalled = 1'b1;
        prev    = bus.tx_data;
      end else begin
        stalled = 1'b0;
      end
      c++;
    end
    check("stall_byte_count", k, BYTES);
    bus.tx_ready = 1'b1;
    wait_idle();
    $display("word src=0 data=%h with stalls done", w);

    // Flush after the second handshake; req[1] waits during SEND, then wins.
    nclk();
    bus.req      = 4'b0001;
    bus.req_data = {64'h0, 32'hA1B2C3D4, 32'h536E6170};
    #1;
    wait_gnt(4'b0001);
    @(posedge clk);
    #1;
    bus.req = 4'b0010;
    nclk();
    check("no_preempt_gnt0", bus.gnt, 0);
    check("flush_b0", bus.tx_data, 8'h53);
    nclk();
    check("no_preempt_gnt1", bus.gnt, 0);
    check("flush_b1", bus.tx_data, 8'h6E);
    nclk();
    bus.flush = 1'b1;
    nclk();
    bus.flush = 1'b0;
    check("flush_valid", bus.tx_valid, 0);
    check("flush_busy", bus.busy, 0);
    run_word(4'b0010, 1, 32'hA1B2C3D4);

    // Flush on the final handshake: no GAP, straight back to IDLE.
    bus.req      = 4'b0001;
    bus.req_data = {96'h0, 32'h0BADF00D};
    #1;
    wait_gnt(4'b0001);
    @(posedge clk);
    #1;
    bus.req = '0;
    nclk();
    for (int b = 0; b < BYTES - 1; b++) nclk();
    check("last_byte", bus.tx_data, 8'h0D);
    bus.flush = 1'b1;
    nclk();
    check("last_flush_busy", bus.busy, 0);
    check("last_flush_valid", bus.tx_valid, 0);
    // Flush while IDLE must not block the grant; byte count restarts cleanly.
    bus.req      = 4'b0001;
    bus.req_data = {96'h0, 32'h13579BDF};
    #1;
    run_word(4'b0001, 0, 32'h13579BDF);

    // Reset during the third byte, then ptr restarts at 0.
    bus.req      = 4'b0100;
    bus.req_data = {32'h0, 32'hCAFEF00D, 32'hA1B2C3D4, 32'h0};
    #1;
    wait_gnt(4'b0100);
    @(posedge clk);
    #1;
    bus.req = '0;
    nclk();
    nclk();
    nclk();
    check("pre_rst_byte2", bus.tx_data, 8'hF0);
    bus.req = 4'b1010;
    nrst    = 1'b0;
    #1;
    check("arst_tx_valid", bus.tx_valid, 0);
    check("arst_tx_data", bus.tx_data, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_cur_src", bus.cur_src, 0);
    check("arst_gnt", bus.gnt, 0);
    nclk();
    nrst = 1'b1;
    #1;
    run_word(4'b0010, 1, 32'hA1B2C3D4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
